// File: rtl/branch_resolve_ctrl_if.sv
// Bus bundle for branch_resolve_ctrl: resolved-branch input handshake,
// flush/redirect outputs and the BTB update write port.
// The slave modport is the controller's view; master is its environment.
// Optional macro BRCTRL_PERF_CNT_EN adds the perf_branches/perf_mispredicts counters.
interface branch_resolve_ctrl_if #(
    parameter int UPD_DEPTH = 4
);
    logic                           res_valid;
    logic                           res_ready;
    logic [31:0]                    res_pc;
    logic [31:0]                    res_target;
    logic                           res_taken;
    logic                           res_mispredict;
    logic                           flush;
    logic                           fetch_stall;
    logic                           redirect_valid;
    logic [31:0]                    redirect_pc;
    logic                           btb_wr_valid;
    logic                           btb_wr_ready;
    logic [31:0]                    btb_wr_pc;
    logic [31:0]                    btb_wr_target;
    logic                           btb_wr_taken;
    logic [$clog2(UPD_DEPTH+1)-1:0] upd_count;
`ifdef BRCTRL_PERF_CNT_EN
    logic [31:0]                    perf_branches;
    logic [31:0]                    perf_mispredicts;

    modport slave (
        input  res_valid, res_pc, res_target, res_taken, res_mispredict, btb_wr_ready,
        output res_ready, flush, fetch_stall, redirect_valid, redirect_pc,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, upd_count,
               perf_branches, perf_mispredicts
    );
    modport master (
        output res_valid, res_pc, res_target, res_taken, res_mispredict, btb_wr_ready,
        input  res_ready, flush, fetch_stall, redirect_valid, redirect_pc,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, upd_count,
               perf_branches, perf_mispredicts
    );
`else
    modport slave (
        input  res_valid, res_pc, res_target, res_taken, res_mispredict, btb_wr_ready,
        output res_ready, flush, fetch_stall, redirect_valid, redirect_pc,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, upd_count
    );
    modport master (
        output res_valid, res_pc, res_target, res_taken, res_mispredict, btb_wr_ready,
        input  res_ready, flush, fetch_stall, redirect_valid, redirect_pc,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, upd_count
    );
`endif
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: on a mispredict, flushes IF/ID for
// FLUSH_CYCLES cycles and then issues a single fetch redirect. Every resolved
// branch is queued as a BTB update and drained through a show-ahead FIFO.
// Optional macro BRCTRL_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int UPD_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_ctrl_if.slave  bus
);
    localparam int AW   = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CNTW = $clog2(UPD_DEPTH + 1);
    localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_t;

    state_t          state, state_nxt;
    logic [FCW-1:0]  fcnt, fcnt_nxt;
    upd_t            mem [UPD_DEPTH];
    upd_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, empty, accept, pop, mis_accept;

    assign full       = (count == CNTW'(UPD_DEPTH));
    assign empty      = (count == '0);
    // Ready depends only on flops, never on res_valid.
    assign bus.res_ready = (state == IDLE) && !full;
    assign accept     = bus.res_valid && bus.res_ready;
    assign mis_accept = accept && bus.res_mispredict;
    assign pop        = !empty && bus.btb_wr_ready;

    // FSM state and flush countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state logic; flush/stall/redirect decode straight from the state flops.
    always_comb begin
        state_nxt          = state;
        fcnt_nxt           = fcnt;
        bus.flush          = 1'b0;
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                if (mis_accept) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                bus.flush       = 1'b1;
                bus.fetch_stall = 1'b1;
                if (fcnt == '0) state_nxt = REDIRECT;
                else            fcnt_nxt  = fcnt - 1'b1;
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.fetch_stall    = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the corrected fetch PC at the mispredict accept (wrapping add).
    always_ff @(posedge clk) begin
        if (reset)           bus.redirect_pc <= '0;
        else if (mis_accept) bus.redirect_pc <= bus.res_taken ? bus.res_target
                                                              : bus.res_pc + 32'd4;
    end

    // Update FIFO storage, pointers and occupancy; runs independently of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{pc: bus.res_pc, target: bus.res_target, taken: bus.res_taken};
                wr_ptr      <= (wr_ptr == AW'(UPD_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == AW'(UPD_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head              = mem[rd_ptr];
    assign bus.btb_wr_valid  = !empty;
    assign bus.btb_wr_pc     = head.pc;
    assign bus.btb_wr_target = head.target;
    assign bus.btb_wr_taken  = head.taken;
    assign bus.upd_count     = count;

`ifdef BRCTRL_PERF_CNT_EN
    // Saturating counts of accepted branches and accepted mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.perf_branches    <= '0;
            bus.perf_mispredicts <= '0;
        end else begin
            if (accept && bus.perf_branches != 32'hFFFF_FFFF)
                bus.perf_branches <= bus.perf_branches + 32'd1;
            if (mis_accept && bus.perf_mispredicts != 32'hFFFF_FFFF)
                bus.perf_mispredicts <= bus.perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule
